// File: rtl/comparator_if.sv
// Sample/result bundle for the threshold comparator: the master drives samples,
// the slave (the comparator) returns the registered flag, BCD digits and count.
interface comparator_if;
   logic [3:0] binary_code;
   logic       in_valid;
   logic       cnt_clear;
   logic       y;
   logic       out_valid;
   logic       bcd_tens;
   logic [3:0] bcd_units;
   logic [7:0] over_count;

   modport master (
      output binary_code,
      output in_valid,
      output cnt_clear,
      input  y,
      input  out_valid,
      input  bcd_tens,
      input  bcd_units,
      input  over_count
   );

   modport slave (
      input  binary_code,
      input  in_valid,
      input  cnt_clear,
      output y,
      output out_valid,
      output bcd_tens,
      output bcd_units,
      output over_count
   );
endinterface

// File: rtl/comparator.sv
// Registered 4-bit threshold comparator with BCD split of the accepted sample
// and a saturating count of over-threshold samples.
module comparator #(
   parameter int unsigned THRESHOLD = 9
) (
   input logic         clk,
   input logic         rst_n,
   comparator_if.slave bus
);

   localparam logic [3:0] THRESH_4  = THRESHOLD[3:0];
   localparam logic [7:0] COUNT_MAX = 8'hFF;

   logic       y_d, y_q;
   logic       out_valid_d, out_valid_q;
   logic       bcd_tens_d, bcd_tens_q;
   logic [3:0] bcd_units_d, bcd_units_q;
   logic [7:0] over_count_d, over_count_q;

   // binary_code is only looked at under in_valid, so idle-cycle X cannot leak into state
   always_comb begin
      y_d          = y_q;
      bcd_tens_d   = bcd_tens_q;
      bcd_units_d  = bcd_units_q;
      over_count_d = over_count_q;
      out_valid_d  = bus.in_valid;
      if (bus.in_valid) begin
         y_d = (bus.binary_code > THRESH_4);
         if (bus.binary_code >= 4'd10) begin
            bcd_tens_d  = 1'b1;
            bcd_units_d = bus.binary_code - 4'd10;
         end else begin
            bcd_tens_d  = 1'b0;
            bcd_units_d = bus.binary_code;
         end
         if (y_d && (over_count_q != COUNT_MAX)) begin
            over_count_d = over_count_q + 8'd1;
         end
      end
      if (bus.cnt_clear) begin
         over_count_d = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q          <= 1'b0;
         out_valid_q  <= 1'b0;
         bcd_tens_q   <= 1'b0;
         bcd_units_q  <= 4'd0;
         over_count_q <= 8'd0;
      end else begin
         y_q          <= y_d;
         out_valid_q  <= out_valid_d;
         bcd_tens_q   <= bcd_tens_d;
         bcd_units_q  <= bcd_units_d;
         over_count_q <= over_count_d;
      end
   end

   assign bus.y          = y_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.bcd_tens   = bcd_tens_q;
   assign bus.bcd_units  = bcd_units_q;
   assign bus.over_count = over_count_q;

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator: directed boundary sequences plus random
// traffic, checked against an arithmetic reference model.
module tb_comparator;
   localparam int unsigned THRESHOLD = 9;

   typedef struct packed {
      logic       y;
      logic       tens;
      logic [3:0] units;
   } sample_t;

   typedef struct packed {
      logic       ov;
      logic [7:0] cnt;
   } cycle_t;

   logic clk;
   logic rst_n;
   comparator_if bus ();

   comparator #(.THRESHOLD(THRESHOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   sample_t data_q[$];
   cycle_t  cyc_q[$];
   int      model_count;
   int      compare_count;
   int      fail_count;
   logic       last_y;
   logic       last_tens;
   logic [3:0] last_units;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      compare_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs just after the falling edge and record what the
   // next rising edge should produce.
   task automatic applyStimulus(input logic [3:0] code, input logic valid, input logic clear);
      sample_t s;
      @(negedge clk);
      #1;
      bus.binary_code = valid ? code : 4'bxxxx;
      bus.in_valid    = valid;
      bus.cnt_clear   = clear;
      if (valid) begin
         s.y     = (int'(code) > int'(THRESHOLD));
         s.tens  = (code >= 4'd10);
         s.units = (code >= 4'd10) ? code - 4'd10 : code;
         data_q.push_back(s);
         if (s.y && model_count < 255) model_count++;
      end
      if (clear) model_count = 0;
      cyc_q.push_back({valid, 8'(model_count)});
   endtask

   // Pulse reset between edges while a fresh sample is being presented.
   task automatic applyMidReset();
      @(negedge clk);
      #1;
      bus.binary_code = 4'd15;
      bus.in_valid    = 1'b1;
      bus.cnt_clear   = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset_y", {7'd0, bus.y}, 8'd0);
      checkOutput("mid_reset_over_count", bus.over_count, 8'd0);
      checkOutput("mid_reset_out_valid", {7'd0, bus.out_valid}, 8'd0);
      bus.in_valid = 1'b0;
      data_q.delete();
      cyc_q.delete();
      model_count = 0;
      last_y      = 1'b0;
      last_tens   = 1'b0;
      last_units  = 4'd0;
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_out_valid", {7'd0, bus.out_valid}, 8'd0);
      checkOutput("post_reset_y", {7'd0, bus.y}, 8'd0);
   endtask

   // Monitor: per-cycle handshake/count checks, sample results popped on out_valid.
   always @(negedge clk) begin
      cycle_t  c;
      sample_t s;
      if (rst_n && cyc_q.size() > 0) begin
         c = cyc_q.pop_front();
         checkOutput("out_valid", {7'd0, bus.out_valid}, {7'd0, c.ov});
         checkOutput("over_count", bus.over_count, c.cnt);
         if (bus.out_valid) begin
            if (data_q.size() == 0) begin
               checkOutput("unexpected_out_valid", 8'd1, 8'd0);
            end else begin
               s = data_q.pop_front();
               checkOutput("y", {7'd0, bus.y}, {7'd0, s.y});
               checkOutput("bcd_tens", {7'd0, bus.bcd_tens}, {7'd0, s.tens});
               checkOutput("bcd_units", {4'd0, bus.bcd_units}, {4'd0, s.units});
               last_y     = s.y;
               last_tens  = s.tens;
               last_units = s.units;
            end
         end else begin
            checkOutput("hold_y", {7'd0, bus.y}, {7'd0, last_y});
            checkOutput("hold_bcd_tens", {7'd0, bus.bcd_tens}, {7'd0, last_tens});
            checkOutput("hold_bcd_units", {4'd0, bus.bcd_units}, {4'd0, last_units});
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      compare_count   = 0;
      fail_count      = 0;
      model_count     = 0;
      last_y          = 1'b0;
      last_tens       = 1'b0;
      last_units      = 4'd0;
      rst_n           = 1'b0;
      bus.binary_code = 4'd0;
      bus.in_valid    = 1'b0;
      bus.cnt_clear   = 1'b0;
      #3;
      checkOutput("reset_y", {7'd0, bus.y}, 8'd0);
      checkOutput("reset_out_valid", {7'd0, bus.out_valid}, 8'd0);
      checkOutput("reset_bcd_tens", {7'd0, bus.bcd_tens}, 8'd0);
      checkOutput("reset_bcd_units", {4'd0, bus.bcd_units}, 8'd0);
      checkOutput("reset_over_count", bus.over_count, 8'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      // Basic values, equality boundary, back-to-back stream.
      applyStimulus(4'd6, 1'b1, 1'b0);
      applyStimulus(4'd9, 1'b1, 1'b0);
      applyStimulus(4'd12, 1'b1, 1'b0);
      applyStimulus(4'd1, 1'b1, 1'b0);
      applyStimulus(4'd15, 1'b1, 1'b0);
      applyStimulus(4'd10, 1'b1, 1'b0);

      // Accept then idle: flag and digits hold, out_valid stays low.
      applyStimulus(4'd12, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(4'd0, 1'b0, 1'b0);

      // Clear without accept, then saturation and clear-beats-increment.
      applyStimulus(4'd0, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) applyStimulus(4'd15, 1'b1, 1'b0);
      applyStimulus(4'd15, 1'b1, 1'b1);
      applyStimulus(4'd11, 1'b1, 1'b0);

      // Reset with y high discards the pending sample.
      applyStimulus(4'd15, 1'b1, 1'b0);
      applyStimulus(4'd0, 1'b0, 1'b0);
      applyMidReset();
      for (int i = 0; i < 2; i++) applyStimulus(4'd0, 1'b0, 1'b0);

      // Random traffic with occasional clears.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      end

      for (int i = 0; i < 3; i++) applyStimulus(4'd0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("drained_samples", 8'(data_q.size()), 8'd0);
      checkOutput("drained_cycles", 8'(cyc_q.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
      $finish;
   end
endmodule

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 Parameter THRESHOLD, default 9: the comparison limit; legal range 0..15; y asserts when the sample is strictly greater.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 binary_code  input  4  unsigned sample to compare.
REQ-005 in_valid  input  1  qualifies binary_code in the current cycle.
REQ-006 cnt_clear  input  1  synchronous clear of over_count.
REQ-007 y  output  1  registered flag: last accepted sample > THRESHOLD.
REQ-008 out_valid  output  1  pulses high one cycle after each accepted sample.
REQ-009 bcd_tens  output  1  registered tens digit of the last accepted sample (0 or 1).
REQ-010 bcd_units  output  4  registered units digit of the last accepted sample (0..9).
REQ-011 over_count  output  8  saturating count of accepted samples with y condition true.

Function
REQ-012 A sample is accepted on a rising clk edge when in_valid=1.
- Latency: 1 cycle; no back-pressure (always ready).
REQ-013 On accept, y SHALL take (binary_code > THRESHOLD) as an unsigned 4-bit compare.
- Equality gives y=0.
REQ-014 On accept, bcd_tens SHALL be 1 and bcd_units SHALL be binary_code-10 when binary_code >= 10.
- Otherwise bcd_tens=0 and bcd_units=binary_code.
- These digits are independent of THRESHOLD.
REQ-015 out_valid SHALL equal the previous cycle's in_valid (registered); it is high for exactly one cycle per accepted sample.
REQ-016 When in_valid=0, y, bcd_tens and bcd_units SHALL hold their last values.
REQ-017 over_count SHALL increment by 1 on each accepted sample whose compare result is 1.
- Saturates at 255; no wrap-around.
REQ-018 When cnt_clear=1, over_count SHALL become 0 on that edge.
- If an increment occurs in the same cycle, the clear wins.
REQ-019 Back-to-back accepts (in_valid high every cycle) SHALL each produce a result in the following cycle with no bubbles.
REQ-020 X/Z on binary_code while in_valid=0 SHALL NOT affect any output.

Reset
REQ-021 While rst_n=0, outputs SHALL immediately be y=0, out_valid=0, bcd_tens=0, bcd_units=0, over_count=0, independent of clk.
REQ-022 Reset asserted mid-stream SHALL discard any in-flight sample; no out_valid pulse follows for it.
REQ-023 The first rising edge after rst_n deasserts SHALL accept a sample normally if in_valid=1.

Verification
REQ-024 Accept 4'b0110 (6), THRESHOLD=9 -> next cycle y=0, bcd_tens=0, bcd_units=6, out_valid=1.
REQ-025 Accept 4'b1001 (9) -> y=0, bcd_tens=0, bcd_units=9 (equality boundary).
REQ-026 Accept 4'b1100 (12), then 4'b0001 (1), then 4'b1111 (15) on consecutive cycles:
- y sequence 1,0,1.
- units sequence 2,1,5; tens sequence 1,0,1.
- over_count ends at 2.
REQ-027 Issue 300 accepts of 4'b1111 -> over_count saturates at 255.
- Asserting cnt_clear together with an accept -> over_count=0.
REQ-028 Accept 12, then deassert in_valid for 3 cycles -> y remains 1 and out_valid=0 during the idle cycles.
REQ-029 Pulse rst_n low between clock edges while y=1 -> y and over_count go to 0 immediately, with no out_valid pulse afterwards.
